load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: one memory byte per cycle, little-endian,
// RV32I width codes with sign/zero extension and alignment checking.
module load_store_unit #(
  parameter int unsigned RegBits = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [2:0]         req_funct3_i,
  input  logic [RegBits-1:0] req_addr_i,
  input  logic [RegBits-1:0] req_wdata_i,
  output logic               resp_valid_o,
  output logic [RegBits-1:0] resp_rdata_o,
  output logic               resp_err_o,
  output logic [RegBits-1:0] mem_a_o,
  output logic [7:0]         mem_wd_o,
  output logic               mem_we_o,
  input  logic [7:0]         mem_rd_i
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [RegBits-1:0] addr_q, addr_d;
  logic [RegBits-1:0] wdata_q, wdata_d;
  logic [1:0]         k_q, k_d;
  logic [RegBits-1:0] asm_q, asm_d;
  logic               err_q, err_d;

  logic               accept;
  logic               req_err;
  logic [1:0]         last_k;
  logic               in_access;
  logic               in_resp;
  logic [RegBits-1:0] load_ext;

  always_comb begin
    case (req_funct3_i)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr_i[0];
      3'b010:  req_err = (req_addr_i[1:0] != 2'b00);
      3'b100:  req_err = req_we_i;
      3'b101:  req_err = req_we_i | req_addr_i[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  assign req_ready_o = (state_q == StIdle);
  assign accept      = req_valid_i && req_ready_o;
  assign in_access   = (state_q == StAccess);
  assign in_resp     = (state_q == StResp);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    k_d      = k_q;
    asm_d    = asm_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          we_d     = req_we_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          k_d      = '0;
          asm_d    = '0;
          err_d    = req_err;
          state_d  = req_err ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (!we_q) begin
          asm_d[{k_q, 3'b000} +: 8] = mem_rd_i;
        end
        k_d = k_q + 2'd1;
        if (k_q == last_k) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      k_q      <= '0;
      asm_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      k_q      <= k_d;
      asm_q    <= asm_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{asm_q[7]}}, asm_q[7:0]};
      3'b001:  load_ext = {{16{asm_q[15]}}, asm_q[15:0]};
      3'b100:  load_ext = {24'b0, asm_q[7:0]};
      3'b101:  load_ext = {16'b0, asm_q[15:0]};
      default: load_ext = asm_q;
    endcase
  end

  // Write enable is gated by reset so that the byte under way when reset
  // arrives is not committed to memory.
  assign mem_we_o     = in_access && we_q && !rst_i;
  assign mem_a_o      = in_access ? (addr_q + RegBits'(k_q)) : '0;
  assign mem_wd_o     = (in_access && we_q) ? wdata_q[{k_q, 3'b000} +: 8] : '0;

  assign resp_valid_o = in_resp;
  assign resp_err_o   = in_resp && err_q;
  assign resp_rdata_o = (in_resp && !err_q && !we_q) ? load_ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random bench for load_store_unit against a byte-array memory
// model and a per-operation reference of expected bytes, timing and results.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic [7:0]  mem_wd;
  logic        mem_we;
  logic [7:0]  mem_rd;

  logic [7:0]  mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  logic        nxt_we;
  logic [2:0]  nxt_f3;
  logic [31:0] nxt_addr;
  logic [31:0] nxt_wdata;

  load_store_unit #(.RegBits(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_a_o      (mem_a),
    .mem_wd_o     (mem_wd),
    .mem_we_o     (mem_we),
    .mem_rd_i     (mem_rd)
  );

  assign mem_rd = mem[mem_a[7:0]];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock: memory commits what the DUT drives before the edge.
  task automatic cycle();
    logic        w;
    logic [31:0] a;
    logic [7:0]  d;
    w = mem_we;
    a = mem_a;
    d = mem_wd;
    @(posedge clk);
    if (w === 1'b1) mem[a[7:0]] = d;
    @(negedge clk);
  endtask

  function automatic int unsigned nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    n = nbytes(f3);
    if (n == 2 && (a % 2) != 0) return 1'b1;
    if (n == 4 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int unsigned i = 0; i < nbytes(f3); i++)
      v = v | (32'(mem[8'(a + i)]) << (8 * i));
    if (f3 == 3'b000 && v >= 32'd128)   v = v - 32'd256;
    if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic [31:0] rd);
    bit          exp_err;
    int unsigned n;
    logic [31:0] exp_rd;
    exp_err = is_err(we, f3, a);
    n       = nbytes(f3);
    exp_rd  = (!we && !exp_err) ? load_value(f3, a) : 32'd0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_we", 32'(mem_we), 32'd0);
    chk("idle_resp", 32'(resp_valid), 32'd0);
    cycle();
    if (hold) begin
      req_we     = nxt_we;
      req_funct3 = nxt_f3;
      req_addr   = nxt_addr;
      req_wdata  = nxt_wdata;
    end else begin
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end
    if (!exp_err) begin
      for (int unsigned k = 0; k < n; k++) begin
        #1;
        chk("acc_ready", 32'(req_ready), 32'd0);
        chk("acc_resp", 32'(resp_valid), 32'd0);
        chk("acc_addr", mem_a, a + k);
        chk("acc_we", 32'(mem_we), 32'(we));
        chk("acc_wd", 32'(mem_wd), we ? ((wd >> (8 * k)) & 32'hFF) : 32'd0);
        cycle();
      end
    end
    #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_we", 32'(mem_we), 32'd0);
    chk("resp_ready", 32'(req_ready), 32'd0);
    rd = resp_rdata;
    cycle();
    #1;
    chk("post_resp", 32'(resp_valid), 32'd0);
    chk("post_err", 32'(resp_err), 32'd0);
    chk("post_rdata", resp_rdata, 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    nxt_we = 1'b0; nxt_f3 = '0; nxt_addr = '0; nxt_wdata = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wd", 32'(mem_wd), 32'd0);

    // SW of a known word
    run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    chk("sw_b0", 32'(mem[8'h10]), 32'hEF);
    chk("sw_b1", 32'(mem[8'h11]), 32'hBE);
    chk("sw_b2", 32'(mem[8'h12]), 32'hAD);
    chk("sw_b3", 32'(mem[8'h13]), 32'hDE);
    chk("sw_rdata", rd, 32'd0);

    // Loads of each width from a fixed pattern
    mem[8'h20] = 8'h80; mem[8'h21] = 8'hFF; mem[8'h22] = 8'h12; mem[8'h23] = 8'h34;
    run_op(1'b0, 3'b000, 32'h20, 32'd0, 1'b0, rd); chk("lb", rd, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h20, 32'd0, 1'b0, rd); chk("lbu", rd, 32'h00000080);
    run_op(1'b0, 3'b001, 32'h20, 32'd0, 1'b0, rd); chk("lh", rd, 32'hFFFFFF80);
    run_op(1'b0, 3'b101, 32'h22, 32'd0, 1'b0, rd); chk("lhu", rd, 32'h00003412);
    run_op(1'b0, 3'b010, 32'h20, 32'd0, 1'b0, rd); chk("lw", rd, 32'h3412FF80);

    // Misaligned and illegal width codes
    run_op(1'b0, 3'b010, 32'h21, 32'd0, 1'b0, rd);        chk("err_lw", rd, 32'd0);
    run_op(1'b1, 3'b001, 32'h03, 32'h1234, 1'b0, rd);     chk("err_sh", rd, 32'd0);
    run_op(1'b1, 3'b100, 32'h30, 32'h55, 1'b0, rd);       chk("err_st100", rd, 32'd0);

    // Address wrap at the top of the space
    run_op(1'b1, 3'b001, 32'hFFFFFFFE, 32'h0000ABCD, 1'b0, rd);
    chk("wrap_b0", 32'(mem[8'hFE]), 32'hCD);
    chk("wrap_b1", 32'(mem[8'hFF]), 32'hAB);

    // Reset in the second byte of a word store
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    #1;
    chk("ra_ready", 32'(req_ready), 32'd1);
    cycle();
    req_valid = 1'b0;
    #1;
    chk("ra_we0", 32'(mem_we), 32'd1);
    chk("ra_wd0", 32'(mem_wd), 32'hEF);
    cycle();
    rst = 1'b1;
    #1;
    chk("ra_we1", 32'(mem_we), 32'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("ra_ready_after", 32'(req_ready), 32'd1);
    chk("ra_mem_a", mem_a, 32'd0);
    chk("ra_mem_wd", 32'(mem_wd), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      #1;
      chk("ra_no_resp", 32'(resp_valid), 32'd0);
      chk("ra_no_we", 32'(mem_we), 32'd0);
    end
    chk("ra_m40", 32'(mem[8'h40]), 32'hEF);
    chk("ra_m41", 32'(mem[8'h41]), 32'h22);
    chk("ra_m42", 32'(mem[8'h42]), 32'h33);
    chk("ra_m43", 32'(mem[8'h43]), 32'h44);

    // Reset coinciding with a request drops the request
    mem[8'h50] = 8'h99;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h50; req_wdata = 32'h77;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rp_ready", 32'(req_ready), 32'd1);
    chk("rp_we", 32'(mem_we), 32'd0);
    cycle();
    #1;
    chk("rp_resp", 32'(resp_valid), 32'd0);
    chk("rp_mem", 32'(mem[8'h50]), 32'h99);

    // Back-to-back with valid held: LBU then SB
    nxt_we = 1'b1; nxt_f3 = 3'b000; nxt_addr = 32'h60; nxt_wdata = 32'h0000005A;
    run_op(1'b0, 3'b100, 32'h20, 32'd0, 1'b1, rd);
    chk("b2b_lbu", rd, 32'h00000080);
    run_op(1'b1, 3'b000, 32'h60, 32'h0000005A, 1'b0, rd);
    chk("b2b_sb", 32'(mem[8'h60]), 32'h5A);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom);
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op(we, f3, a, $urandom, 1'b0, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
